// File: rtl/axil_mst_pkg.sv
// Shared constants for the AXI4-Lite single-outstanding master.
//   State encodings for the transaction FSM and AXI response/prot codes.
package axil_mst_pkg;

  // Transaction FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WADDR = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RSP   = 3'd5;

  // AXI response and protection codes
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXPROT_PLAIN = 3'b000;

endpackage

// File: rtl/axil_mst.sv
// AXI4-Lite master: converts a simple core request/response handshake into
// one AXI4-Lite read or write transaction at a time (no pipelining).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_*                core request (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                core response (valid/ready, rdata, err)
//   mst_axi_aw*/w*/b*    AXI4-Lite write address, write data, write response
//   mst_axi_ar*/r*       AXI4-Lite read address, read data
module axil_mst
  import axil_mst_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   mst_axi_awaddr,
  output logic [2:0]          mst_axi_awprot,
  output logic                mst_axi_awvalid,
  input  logic                mst_axi_awready,
  output logic [DATA_W-1:0]   mst_axi_wdata,
  output logic [DATA_W/8-1:0] mst_axi_wstrb,
  output logic                mst_axi_wvalid,
  input  logic                mst_axi_wready,
  input  logic [1:0]          mst_axi_bresp,
  input  logic                mst_axi_bvalid,
  output logic                mst_axi_bready,
  output logic [ADDR_W-1:0]   mst_axi_araddr,
  output logic [2:0]          mst_axi_arprot,
  output logic                mst_axi_arvalid,
  input  logic                mst_axi_arready,
  input  logic [DATA_W-1:0]   mst_axi_rdata,
  input  logic [1:0]          mst_axi_rresp,
  input  logic                mst_axi_rvalid,
  output logic                mst_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [2:0]        state_q, state_d;
  logic              req_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [STRB_W-1:0] wstrb_d;

  logic [ADDR_W-1:0] addr_aligned_c;
  logic              aw_fire_c, w_fire_c;

  // AXI-Lite is word-addressed here: drop the byte offset
  assign addr_aligned_c = {req_addr_i[ADDR_W-1:2], 2'b00};
  assign aw_fire_c      = mst_axi_awvalid & mst_axi_awready;
  assign w_fire_c       = mst_axi_wvalid & mst_axi_wready;

  assign mst_axi_awprot = AXPROT_PLAIN;
  assign mst_axi_arprot = AXPROT_PLAIN;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      req_ready_o     <= 1'b1;
      rsp_valid_o     <= 1'b0;
      rsp_err_o       <= 1'b0;
      rsp_rdata_o     <= '0;
      mst_axi_awvalid <= 1'b0;
      mst_axi_wvalid  <= 1'b0;
      mst_axi_bready  <= 1'b0;
      mst_axi_arvalid <= 1'b0;
      mst_axi_rready  <= 1'b0;
      mst_axi_awaddr  <= '0;
      mst_axi_araddr  <= '0;
      mst_axi_wdata   <= '0;
      mst_axi_wstrb   <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_o     <= req_ready_d;
      rsp_valid_o     <= rsp_valid_d;
      rsp_err_o       <= rsp_err_d;
      rsp_rdata_o     <= rsp_rdata_d;
      mst_axi_awvalid <= awvalid_d;
      mst_axi_wvalid  <= wvalid_d;
      mst_axi_bready  <= bready_d;
      mst_axi_arvalid <= arvalid_d;
      mst_axi_rready  <= rready_d;
      mst_axi_awaddr  <= awaddr_d;
      mst_axi_araddr  <= araddr_d;
      mst_axi_wdata   <= wdata_d;
      mst_axi_wstrb   <= wstrb_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_o;
    rsp_valid_d = rsp_valid_o;
    rsp_err_d   = rsp_err_o;
    rsp_rdata_d = rsp_rdata_o;
    awvalid_d   = mst_axi_awvalid;
    wvalid_d    = mst_axi_wvalid;
    bready_d    = mst_axi_bready;
    arvalid_d   = mst_axi_arvalid;
    rready_d    = mst_axi_rready;
    awaddr_d    = mst_axi_awaddr;
    araddr_d    = mst_axi_araddr;
    wdata_d     = mst_axi_wdata;
    wstrb_d     = mst_axi_wstrb;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_ready_d = 1'b0;
          if (req_we_i) begin
            awaddr_d  = addr_aligned_c;
            wdata_d   = req_wdata_i;
            wstrb_d   = req_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            araddr_d  = addr_aligned_c;
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end

      // AW and W retire independently; leave only once both have fired
      ST_WADDR: begin
        if (aw_fire_c) awvalid_d = 1'b0;
        if (w_fire_c)  wvalid_d  = 1'b0;
        if ((!mst_axi_awvalid || aw_fire_c) && (!mst_axi_wvalid || w_fire_c)) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end

      ST_WRESP: begin
        if (mst_axi_bvalid && mst_axi_bready) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (mst_axi_bresp != RESP_OKAY);
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end

      ST_RADDR: begin
        if (mst_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end

      ST_RDATA: begin
        if (mst_axi_rvalid && mst_axi_rready) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (mst_axi_rresp != RESP_OKAY);
          rsp_rdata_d = mst_axi_rdata;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_mst.sv
// Bench for axil_mst: table-driven directed vectors, randomized transactions
// checked against a cycle-count/response reference model, and hand-written
// sequences for B-early, response backpressure and mid-transaction reset.
module tb_axil_mst;

  logic        clk, rst;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_mst #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mst_axi_awaddr(awaddr), .mst_axi_awprot(awprot), .mst_axi_awvalid(awvalid),
    .mst_axi_awready(awready),
    .mst_axi_wdata(wdata), .mst_axi_wstrb(wstrb), .mst_axi_wvalid(wvalid),
    .mst_axi_wready(wready),
    .mst_axi_bresp(bresp), .mst_axi_bvalid(bvalid), .mst_axi_bready(bready),
    .mst_axi_araddr(araddr), .mst_axi_arprot(arprot), .mst_axi_arvalid(arvalid),
    .mst_axi_arready(arready),
    .mst_axi_rdata(rdata), .mst_axi_rresp(rresp), .mst_axi_rvalid(rvalid),
    .mst_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model (acts on falling edges) ----------------
  int unsigned cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  bit          cfg_b_always;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit          aw_done, w_done, ar_done;
  bit          p_aw, p_w, p_b, p_ar, p_r;
  int          aw_hi, w_hi, ar_hi, b_hs, r_hs, b_early;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic slave_clear_stats();
    aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0; r_hs = 0; b_early = 0;
    cap_awaddr = 'x; cap_wdata = 'x; cap_araddr = 'x; cap_wstrb = 'x;
  endtask

  task automatic slave_step();
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    end else begin
      // effects of handshakes that happened on the last rising edge
      if (p_aw) begin aw_done = 1; aw_wait = 0; end
      if (p_w)  begin w_done = 1;  w_wait = 0;  end
      if (p_b)  begin aw_done = 0; w_done = 0; b_wait = 0; b_hs++; bvalid = 0; end
      if (p_ar) begin ar_done = 1; ar_wait = 0; end
      if (p_r)  begin ar_done = 0; r_wait = 0; rvalid = 0; r_hs++; end

      if (awvalid) begin
        aw_hi++;
        if (aw_wait >= cfg_aw_d) awready = 1; else begin awready = 0; aw_wait++; end
      end else awready = 0;
      if (wvalid) begin
        w_hi++;
        if (w_wait >= cfg_w_d) wready = 1; else begin wready = 0; w_wait++; end
      end else wready = 0;

      if (cfg_b_always) bvalid = 1;
      else if (!(aw_done && w_done)) bvalid = 0;
      else if (!bvalid) begin
        if (b_wait >= cfg_b_d) bvalid = 1; else b_wait++;
      end
      bresp = cfg_bresp;
      if (bready && !(aw_done && w_done)) b_early++;

      if (arvalid) begin
        ar_hi++;
        if (ar_wait >= cfg_ar_d) arready = 1; else begin arready = 0; ar_wait++; end
      end else arready = 0;
      if (ar_done && !rvalid) begin
        if (r_wait >= cfg_r_d) rvalid = 1; else r_wait++;
      end
      rresp = cfg_rresp;
      rdata = rvalid ? cfg_rdata : 32'h0;

      p_aw = awvalid && awready; if (p_aw) cap_awaddr = awaddr;
      p_w  = wvalid && wready;   if (p_w) begin cap_wdata = wdata; cap_wstrb = wstrb; end
      p_b  = bvalid && bready;
      p_ar = arvalid && arready; if (p_ar) cap_araddr = araddr;
      p_r  = rvalid && rready;
    end
  endtask

  initial begin
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  // ---------------- vectors and reference model ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int unsigned aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] e_rdata;
    bit          e_err;
    int          e_lat;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mkv(bit we, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws,
                               int unsigned awd, int unsigned wd_d, int unsigned bd,
                               int unsigned ard, int unsigned rd_d,
                               logic [1:0] br, logic [1:0] rr, logic [31:0] rdat, int hold,
                               logic [31:0] e_rd, bit e_err, int e_lat, logic [31:0] e_addr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = ws;
    v.aw_d = awd; v.w_d = wd_d; v.b_d = bd; v.ar_d = ard; v.r_d = rd_d;
    v.bresp = br; v.rresp = rr; v.rdata = rdat; v.hold = hold;
    v.e_rdata = e_rd; v.e_err = e_err; v.e_lat = e_lat; v.e_addr = e_addr;
    return v;
  endfunction

  // Response = what the slave answered; latency = 3 cycles plus every stall cycle
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int unsigned m = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    r.e_addr  = v.addr & ~32'h3;
    r.e_rdata = v.we ? 32'h0 : v.rdata;
    r.e_err   = v.we ? (v.bresp != 2'b00) : (v.rresp != 2'b00);
    r.e_lat   = v.we ? int'(3 + m + v.b_d) : int'(3 + v.ar_d + v.r_d);
    return r;
  endfunction

  task automatic run_txn(input vec_t v, output logic [31:0] rd, output logic er,
                         output int lat, output bit st_ok, output bit to, output bit post_ok);
    int k;
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d; cfg_ar_d = v.ar_d; cfg_r_d = v.r_d;
    cfg_bresp = v.bresp; cfg_rresp = v.rresp; cfg_rdata = v.rdata;
    slave_clear_stats();
    st_ok = 1; to = 0; post_ok = 0; rd = 'x; er = 'x;
    @(negedge clk);
    req_valid_i = 1; req_we_i = v.we; req_addr_i = v.addr;
    req_wdata_i = v.wdata; req_wstrb_i = v.wstrb;
    k = 0;
    while (!req_ready_o && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid_i = 0; req_addr_i = $urandom; req_wdata_i = $urandom;
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      if (req_ready_o) st_ok = 0;
      @(negedge clk); lat++;
    end
    if (!rsp_valid_o) begin to = 1; return; end
    rd = rsp_rdata_o; er = rsp_err_o;
    for (int i = 0; i < v.hold; i++) begin
      if (!rsp_valid_o || rsp_rdata_o !== rd || rsp_err_o !== er || req_ready_o) st_ok = 0;
      @(negedge clk);
    end
    if (!rsp_valid_o || rsp_rdata_o !== rd || rsp_err_o !== er || req_ready_o) st_ok = 0;
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    post_ok = !rsp_valid_o && req_ready_o;
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    logic [31:0] rd; logic er; int lat; bit st_ok, to, post_ok;
    run_txn(v, rd, er, lat, st_ok, to, post_ok);
    chk({tag, ".timeout"}, 64'(to), 64'(0));
    chk({tag, ".rdata"}, 64'(rd), 64'(v.e_rdata));
    chk({tag, ".err"}, 64'(er), 64'(v.e_err));
    chk({tag, ".latency"}, 64'(lat), 64'(v.e_lat));
    chk({tag, ".hold_stable"}, 64'(st_ok), 64'(1));
    chk({tag, ".release"}, 64'(post_ok), 64'(1));
    if (v.we) begin
      chk({tag, ".awaddr"}, 64'(cap_awaddr), 64'(v.e_addr));
      chk({tag, ".wdata"}, {28'h0, cap_wstrb, cap_wdata}, {28'h0, v.wstrb, v.wdata});
      chk({tag, ".aw_cycles"}, 64'(aw_hi), 64'(v.aw_d + 1));
      chk({tag, ".w_cycles"}, 64'(w_hi), 64'(v.w_d + 1));
      chk({tag, ".b_count"}, 64'(b_hs), 64'(1));
      chk({tag, ".b_early"}, 64'(b_early), 64'(0));
    end else begin
      chk({tag, ".araddr"}, 64'(cap_araddr), 64'(v.e_addr));
      chk({tag, ".ar_cycles"}, 64'(ar_hi), 64'(v.ar_d + 1));
      chk({tag, ".r_count"}, 64'(r_hs), 64'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t tbl[6];

  initial begin
    vec_t v;
    bit seen;
    rst = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
    req_wstrb_i = 0; rsp_ready_i = 0; cfg_b_always = 0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    slave_clear_stats();

    //         we addr          wdata         strb aw w  b  ar r  bresp rresp rdata        hold  e_rdata       err lat e_addr
    tbl[0] = mkv(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        0, 32'h0,        0, 3, 32'h0000_0010);
    tbl[1] = mkv(1, 32'h0000_0104, 32'hA5A5_0001, 4'h3, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        0, 32'h0,        0, 6, 32'h0000_0104);
    tbl[2] = mkv(0, 32'h0000_0023, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h1234_5678, 0, 32'h1234_5678, 1, 3, 32'h0000_0020);
    tbl[3] = mkv(1, 32'h0000_0007, 32'h0102_0304, 4'h8, 0, 2, 1, 0, 0, 2'b11, 2'b00, 32'h0,        0, 32'h0,        1, 6, 32'h0000_0004);
    tbl[4] = mkv(0, 32'hFFFF_FFFE, 32'h0,         4'h0, 0, 0, 0, 2, 3, 2'b00, 2'b00, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0, 8, 32'hFFFF_FFFC);
    tbl[5] = mkv(0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_C0DE, 5, 32'h0BAD_C0DE, 0, 3, 32'h0000_0040);

    // reset values
    @(negedge clk); @(negedge clk);
    chk("reset.ctrl", {56'h0, req_ready_o, rsp_valid_o, rsp_err_o, awvalid, wvalid, bready, arvalid, rready},
        {56'h0, 8'b1000_0000});
    chk("reset.data", {rsp_rdata_o, awaddr}, 64'h0);
    chk("reset.wdata", {wdata, araddr}, 64'h0);
    chk("reset.strb_prot", {57'h0, wstrb, awprot}, 64'h0);
    rst = 0;
    @(negedge clk);
    chk("reset.release", {62'h0, req_ready_o, rsp_valid_o}, {62'h0, 2'b10});

    foreach (tbl[i]) run_and_check(tbl[i], $sformatf("vec%0d", i));

    // slave holds bvalid high the whole time: must not be consumed early
    cfg_b_always = 1;
    v = model(mkv(1, 32'h0000_0200, 32'h5555_AAAA, 4'hC, 2, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 0, 0));
    run_and_check(v, "bhigh");
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid_o) seen = 1; end
    chk("bhigh.single_rsp", {62'h0, seen, 1'b0} | 64'(b_hs), 64'(1));
    cfg_b_always = 0;

    // reset while in WADDR abandons the write
    cfg_aw_d = 20; cfg_w_d = 20; slave_clear_stats();
    @(negedge clk);
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h0000_0300;
    req_wdata_i = 32'h1111_2222; req_wstrb_i = 4'hF;
    @(negedge clk);
    req_valid_i = 0;
    chk("rst_mid.in_waddr", {62'h0, awvalid, wvalid}, 64'h3);
    #2 rst = 1;
    #1 chk("rst_mid.async_drop", {61'h0, awvalid, wvalid, req_ready_o}, 64'h1);
    @(negedge clk); @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid_o) seen = 1; end
    chk("rst_mid.no_rsp", 64'(seen), 64'(0));
    run_and_check(tbl[0], "rst_mid.after");

    // randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      v = mkv($urandom_range(0, 1), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom), 2'($urandom), $urandom, $urandom_range(0, 2), 0, 0, 0, 0);
      run_and_check(model(v), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
